// File: rtl/ray_dispatch_queue.sv
// Ray dispatch queue: an in-order FIFO of primary rays between the ray generator and the
// octree traversal unit. Rays with an all-zero direction are accepted but discarded and
// counted. The pixel loop index of the head entry is decoded into pixel column and row.
module ray_dispatch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DIR_W      = 12,
    parameter int unsigned IDX_W      = 32,
    parameter int unsigned LOG2_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DIR_W-1:0]       in_dir_x,
    input  logic signed [DIR_W-1:0]       in_dir_y,
    input  logic signed [DIR_W-1:0]       in_dir_z,
    input  logic signed [IDX_W-1:0]       in_index,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DIR_W-1:0]       out_dir_x,
    output logic signed [DIR_W-1:0]       out_dir_y,
    output logic signed [DIR_W-1:0]       out_dir_z,
    output logic signed [IDX_W-1:0]       out_index,
    output logic [LOG2_WIDTH-1:0]         out_pix_x,
    output logic [IDX_W-LOG2_WIDTH-1:0]   out_pix_y,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [15:0]                   drop_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [15:0]     drop_q, drop_d;

    logic signed [DIR_W-1:0] mem_x [DEPTH];
    logic signed [DIR_W-1:0] mem_y [DEPTH];
    logic signed [DIR_W-1:0] mem_z [DEPTH];
    logic signed [IDX_W-1:0] mem_idx [DEPTH];

    logic push, pop, zero_dir, store, drop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Handshake decode; in_ready looks only at registered occupancy and flush.
    always_comb begin
        in_ready  = !flush && (count_q < CntW'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        zero_dir  = (in_dir_x == '0) && (in_dir_y == '0) && (in_dir_z == '0);
        store     = push && !zero_dir;
        drop      = push && zero_dir;
        // A pop coinciding with flush is ignored; flush wins.
        pop       = out_valid && out_ready && !flush;
    end

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
            if (store && !pop)      count_d = count_q + CntW'(1);
            else if (!store && pop) count_d = count_q - CntW'(1);
        end
        if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage; contents need no reset since outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_x[wr_ptr_q]   <= in_dir_x;
            mem_y[wr_ptr_q]   <= in_dir_y;
            mem_z[wr_ptr_q]   <= in_dir_z;
            mem_idx[wr_ptr_q] <= in_index;
        end
    end

    // Head entry output, forced to zero while the queue is empty.
    always_comb begin
        out_dir_x = '0;
        out_dir_y = '0;
        out_dir_z = '0;
        out_index = '0;
        if (out_valid) begin
            out_dir_x = mem_x[rd_ptr_q];
            out_dir_y = mem_y[rd_ptr_q];
            out_dir_z = mem_z[rd_ptr_q];
            out_index = mem_idx[rd_ptr_q];
        end
        out_pix_x  = out_index[LOG2_WIDTH-1:0];
        out_pix_y  = out_index[IDX_W-1:LOG2_WIDTH];
        count      = count_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_ray_dispatch_queue.sv
`timescale 1ns/1ps
module tb_ray_dispatch_queue;

    localparam int DEPTH = 4;
    localparam int DIR_W = 12;
    localparam int IDX_W = 32;
    localparam int LW    = 8;

    typedef struct packed {
        logic signed [DIR_W-1:0] x;
        logic signed [DIR_W-1:0] y;
        logic signed [DIR_W-1:0] z;
        logic signed [IDX_W-1:0] idx;
    } ray_t;

    logic clk = 1'b0;
    logic reset_n, flush, in_valid, out_ready;
    logic signed [DIR_W-1:0] in_dir_x, in_dir_y, in_dir_z;
    logic signed [IDX_W-1:0] in_index;
    logic in_ready, out_valid;
    logic signed [DIR_W-1:0] out_dir_x, out_dir_y, out_dir_z;
    logic signed [IDX_W-1:0] out_index;
    logic [LW-1:0] out_pix_x;
    logic [IDX_W-LW-1:0] out_pix_y;
    logic [2:0] count;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of stored rays plus a saturating drop counter.
    ray_t mq[$];
    int   m_drops = 0;
    int   m_sent = 0;

    always #5 clk = ~clk;

    ray_dispatch_queue #(.DEPTH(DEPTH), .DIR_W(DIR_W), .IDX_W(IDX_W), .LOG2_WIDTH(LW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dir_x(in_dir_x), .in_dir_y(in_dir_y), .in_dir_z(in_dir_z), .in_index(in_index),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dir_x(out_dir_x), .out_dir_y(out_dir_y), .out_dir_z(out_dir_z),
        .out_index(out_index), .out_pix_x(out_pix_x), .out_pix_y(out_pix_y),
        .count(count), .drop_count(drop_count)
    );

    // Advance the model with the inputs present at the coming edge, then clock the DUT.
    task automatic tick();
        bit do_push, do_pop;
        ray_t r;
        if (!reset_n) begin
            mq.delete();
            m_drops = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() != 0) && out_ready;
            do_push = in_valid && (mq.size() < DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (in_dir_x == 0 && in_dir_y == 0 && in_dir_z == 0) begin
                    if (m_drops < 65535) m_drops++;
                end else begin
                    r = '{in_dir_x, in_dir_y, in_dir_z, in_index};
                    mq.push_back(r);
                    m_sent++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ray(input int x, input int y, input int z, input int idx);
        in_dir_x = DIR_W'(x);
        in_dir_y = DIR_W'(y);
        in_dir_z = DIR_W'(z);
        in_index = idx;
    endtask

    task automatic test_reset();
        reset_n = 0; flush = 0; in_valid = 0; out_ready = 0;
        set_ray(0, 0, 0, 0);
        tick(); tick();
        reset_n = 1;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL reset: count=%0d out_valid=%0b in_ready=%0b drop=%0d required 0/0/1/0",
                     count, out_valid, in_ready, drop_count);
        end
        checks++;
        if (out_index !== 0 || out_dir_x !== 0) begin
            failures++;
            $display("FAIL reset_out_zero: out_index=%h out_dir_x=%h required 0", out_index, out_dir_x);
        end
    endtask

    task automatic test_first_push();
        out_ready = 0; in_valid = 1;
        set_ray(3, -2, 1, 32'h0000_0105);
        tick();
        in_valid = 0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pix_x !== 8'd5 || out_pix_y !== 24'd1 || count !== 3'd1) begin
            failures++;
            $display("FAIL first_push: valid=%0b pix_x=%0d pix_y=%0d count=%0d required 1/5/1/1",
                     out_valid, out_pix_x, out_pix_y, count);
        end
        checks++;
        if (out_dir_x !== 12'sd3 || out_dir_y !== -12'sd2 || out_dir_z !== 12'sd1) begin
            failures++;
            $display("FAIL first_dir: got (%0d,%0d,%0d) required (3,-2,1)",
                     out_dir_x, out_dir_y, out_dir_z);
        end
    endtask

    task automatic test_fill();
        out_ready = 0;
        for (int i = 1; i < DEPTH; i++) begin
            in_valid = 1;
            set_ray(i + 10, -i, i * 7, 32'h1000 + i);
            tick();
        end
        in_valid = 0;
        #1;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill: count=%0d in_ready=%0b required 4/0", count, in_ready);
        end
        in_valid = 1;
        set_ray(99, 99, 99, 32'hDEAD);
        tick();
        in_valid = 0;
        #1;
        checks++;
        if (count !== 3'd4 || out_index !== 32'h105 || out_dir_x !== 12'sd3) begin
            failures++;
            $display("FAIL full_hold: count=%0d idx=%h dir_x=%0d required 4/105/3",
                     count, out_index, out_dir_x);
        end
    endtask

    task automatic test_stream();
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1;
            set_ray(i + 1, 2 * i + 1, -i - 1, 32'h2000 + i);
            #2;
            checks++;
            if (out_valid !== 1'b1 || out_index !== mq[0].idx || out_dir_x !== mq[0].x
                || in_ready !== (mq.size() < DEPTH)) begin
                failures++;
                $display("FAIL stream[%0d]: valid=%0b idx=%h in_ready=%0b required 1/%h/%0b",
                         i, out_valid, out_index, in_ready, mq[0].idx, mq.size() < DEPTH);
            end
            tick();
        end
        in_valid = 0;
        for (int i = 0; i < DEPTH + 2 && mq.size() != 0; i++) begin
            #2;
            checks++;
            if (out_index !== mq[0].idx || out_dir_z !== mq[0].z) begin
                failures++;
                $display("FAIL drain[%0d]: idx=%h required %h", i, out_index, mq[0].idx);
            end
            tick();
        end
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: count=%0d valid=%0b required 0/0", count, out_valid);
        end
    endtask

    task automatic test_drop();
        out_ready = 0; in_valid = 1;
        set_ray(5, 0, 0, 32'h3000);
        tick();
        set_ray(0, 0, 0, 7);
        tick();
        in_valid = 0;
        #1;
        checks++;
        if (count !== 3'd1 || drop_count !== 16'd1) begin
            failures++;
            $display("FAIL drop_one: count=%0d drop=%0d required 1/1", count, drop_count);
        end
        in_valid = 1;
        for (int i = 0; i < 65540; i++) tick();
        #1;
        checks++;
        if (drop_count !== 16'hFFFF || count !== 3'd1) begin
            failures++;
            $display("FAIL drop_sat: drop=%h count=%0d required FFFF/1", drop_count, count);
        end
        // Zero ray together with a pop: occupancy falls, drop stays saturated.
        out_ready = 1;
        tick();
        in_valid = 0; out_ready = 0;
        #1;
        checks++;
        if (count !== 3'd0 || drop_count !== 16'hFFFF || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_pop: count=%0d drop=%h valid=%0b required 0/FFFF/0",
                     count, drop_count, out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            set_ray(i + 1, 1, 1, 32'h4000 + i);
            tick();
        end
        flush = 1; out_ready = 1;
        set_ray(7, 7, 7, 32'h4BAD);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: in_ready=%0b required 0", in_ready);
        end
        tick();
        flush = 0; in_valid = 0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || drop_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL flush: count=%0d valid=%0b drop=%h required 0/0/FFFF",
                     count, out_valid, drop_count);
        end
        in_valid = 1; out_ready = 0;
        set_ray(2, 4, 6, 32'h4100);
        tick();
        in_valid = 0;
        #1;
        checks++;
        if (out_index !== 32'h4100 || count !== 3'd1) begin
            failures++;
            $display("FAIL flush_after: idx=%h count=%0d required 4100/1", out_index, count);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1;
        set_ray(1, 2, 3, 32'h5000);
        tick();
        in_valid = 0;
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid: count=%0d valid=%0b in_ready=%0b drop=%0d required 0/0/1/0",
                     count, out_valid, in_ready, drop_count);
        end
    endtask

    task automatic test_random();
        int received = 0;
        int kind;
        m_sent = 0;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 5);
            kind = $urandom_range(0, 7);
            if (kind == 0)      set_ray(0, 0, 0, $urandom);
            else if (kind == 1) set_ray(0, 0, $urandom_range(1, 2047), $urandom);
            else                set_ray($urandom, $urandom, $urandom, $urandom);
            #2;
            checks++;
            if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0)
                || in_ready !== (mq.size() < DEPTH)) begin
                failures++;
                $display("FAIL rand_ctrl[%0d]: count=%0d valid=%0b ready=%0b required %0d",
                         i, count, out_valid, in_ready, mq.size());
            end
            if (mq.size() != 0) begin
                checks++;
                if (out_index !== mq[0].idx || out_dir_x !== mq[0].x || out_dir_y !== mq[0].y
                    || out_dir_z !== mq[0].z) begin
                    failures++;
                    $display("FAIL rand_data[%0d]: idx=%h dir=(%0d,%0d,%0d) required %h (%0d,%0d,%0d)",
                             i, out_index, out_dir_x, out_dir_y, out_dir_z,
                             mq[0].idx, mq[0].x, mq[0].y, mq[0].z);
                end
            end
            if (out_valid && out_ready) received++;
            tick();
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            #2;
            if (out_valid) received++;
            tick();
        end
        checks++;
        if (received !== m_sent || count !== 3'd0) begin
            failures++;
            $display("FAIL rand_total: received=%0d count=%0d required %0d/0", received, count, m_sent);
        end
        checks++;
        if (drop_count !== 16'(m_drops)) begin
            failures++;
            $display("FAIL rand_drops: drop=%0d required %0d", drop_count, m_drops);
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill();
        test_stream();
        test_drop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
